// File: rtl/wire4_pkg.sv
// Shared types and helpers for the wire4 self-check sequencer: FSM states,
// LFSR feedback taps and the reference wire4 output mapping.
package wire4_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

   // x^16+x^14+x^13+x^11+1 -> state bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [3:0] wire4_expect(input logic [2:0] abc);
      return {abc[2], abc[1], abc[1], abc[0]};
   endfunction

endpackage

// File: rtl/wire4_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous reseed and single-step advance.
module wire4_lfsr
   import wire4_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic        i_step,
   output logic [15:0] o_state
);

   logic [15:0] r_state;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= SEED;
      end else if (i_load) begin
         r_state <= SEED;
      end else if (i_step) begin
         r_state <= lfsr_next(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/wire4_check_sequencer.sv
// Self-check sequencer for the wire4 routing block: drives LFSR vectors,
// checks the response one cycle later and accumulates saturating error counts.
module wire4_check_sequencer
   import wire4_pkg::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_num_vectors,
   output logic [2:0]       o_abc,
   input  logic [3:0]       i_wxyz,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [CNT_W-1:0] o_err_w,
   output logic [CNT_W-1:0] o_err_x,
   output logic [CNT_W-1:0] o_err_y,
   output logic [CNT_W-1:0] o_err_z,
   output logic [CNT_W-1:0] o_total_errors,
   output logic [CNT_W-1:0] o_first_err_idx,
   output logic [CNT_W-1:0] o_vec_count
);

   localparam logic [CNT_W-1:0] ALL_ONES = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != ALL_ONES)) ? v + 1'b1 : v;
   endfunction

   state_t           r_state, w_state_d;
   logic [CNT_W-1:0] r_num_vectors, r_err_w, r_err_x, r_err_y, r_err_z;
   logic [CNT_W-1:0] r_total, r_first_idx, r_vec_count, w_vec_inc;
   logic [2:0]       r_abc;
   logic             r_busy, r_pass, w_load, w_step, w_last;
   logic [3:0]       w_mis;
   logic [15:0]      w_lfsr;

   wire4_lfsr #(.SEED(SEED)) u_lfsr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_load),
      .i_step  (w_step),
      .o_state (w_lfsr)
   );

   assign w_mis     = i_wxyz ^ wire4_expect(r_abc);
   assign w_vec_inc = r_vec_count + 1'b1;
   assign w_last    = (w_vec_inc == r_num_vectors);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      w_load    = 1'b0;
      w_step    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_load    = 1'b1;
               w_state_d = (i_num_vectors == '0) ? FIN : DRIVE;
            end
         end
         DRIVE: begin
            w_step    = 1'b1;
            w_state_d = CHECK;
         end
         CHECK:   w_state_d = w_last ? FIN : DRIVE;
         FIN:     w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_num_vectors <= '0;
         r_abc         <= '0;
         r_busy        <= 1'b0;
         r_pass        <= 1'b0;
         r_err_w       <= '0;
         r_err_x       <= '0;
         r_err_y       <= '0;
         r_err_z       <= '0;
         r_total       <= '0;
         r_first_idx   <= ALL_ONES;
         r_vec_count   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_num_vectors <= i_num_vectors;
                  r_busy        <= 1'b1;
                  r_pass        <= 1'b0;
                  r_err_w       <= '0;
                  r_err_x       <= '0;
                  r_err_y       <= '0;
                  r_err_z       <= '0;
                  r_total       <= '0;
                  r_first_idx   <= ALL_ONES;
                  r_vec_count   <= '0;
               end
            end
            DRIVE: r_abc <= w_lfsr[2:0];
            CHECK: begin
               r_err_w <= sat_inc(r_err_w, w_mis[3]);
               r_err_x <= sat_inc(r_err_x, w_mis[2]);
               r_err_y <= sat_inc(r_err_y, w_mis[1]);
               r_err_z <= sat_inc(r_err_z, w_mis[0]);
               r_total <= sat_inc(r_total, |w_mis);
               // Only the first failing vector of the run is recorded
               if ((|w_mis) && (r_total == '0)) r_first_idx <= r_vec_count;
               r_vec_count <= w_vec_inc;
            end
            FIN: begin
               r_pass <= (r_total == '0);
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_abc           = r_abc;
   assign o_busy          = r_busy;
   assign o_done          = (r_state == FIN);
   assign o_pass          = r_pass;
   assign o_err_w         = r_err_w;
   assign o_err_x         = r_err_x;
   assign o_err_y         = r_err_y;
   assign o_err_z         = r_err_z;
   assign o_total_errors  = r_total;
   assign o_first_err_idx = r_first_idx;
   assign o_vec_count     = r_vec_count;

endmodule

// File: tb/tb_wire4_check_sequencer.sv
// Bench for wire4_check_sequencer: fault-injecting wire4 models on two instances
// (16-bit and 4-bit counters) checked against an LFSR-sequence reference model.
module tb_wire4_check_sequencer;

   localparam logic [15:0] SEED = 16'hACE1;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        pass;
      logic [2:0]  abc;
      logic [15:0] ew, ex, ey, ez, tot, fidx, vc;
   } res_t;

   logic clk = 1'b0, rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [15:0] nv0 = '0;
   logic [3:0]  nv1 = '0;
   logic [2:0]  abc0, abc1;
   logic [3:0]  wxyz0, wxyz1;
   logic busy0, done0, pass0, busy1, done1, pass1;
   logic [15:0] ew0, ex0, ey0, ez0, tot0, fidx0, vc0;
   logic [3:0]  ew1, ex1, ey1, ez1, tot1, fidx1, vc1;
   int mode0 = 0, mode1 = 0;
   int n_cmp = 0, n_err = 0;
   logic [2:0] last_abc [2];

   always #5 clk = ~clk;

   // Block under test models: 0 ideal, 1 z stuck-at-0, 2 x=a/y=c, 3 all inverted
   function automatic logic [3:0] resp(input logic [2:0] v, input int md);
      case (md)
         1:       return {v[2], v[1], v[1], 1'b0};
         2:       return {v[2], v[2], v[0], v[0]};
         3:       return ~{v[2], v[1], v[1], v[0]};
         default: return {v[2], v[1], v[1], v[0]};
      endcase
   endfunction

   always_comb wxyz0 = resp(abc0, mode0);
   always_comb wxyz1 = resp(abc1, mode1);

   wire4_check_sequencer #(.CNT_W(16), .SEED(SEED)) u_dut0 (
      .i_clk(clk), .i_reset(rst), .i_start(start0), .i_num_vectors(nv0),
      .o_abc(abc0), .i_wxyz(wxyz0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
      .o_err_w(ew0), .o_err_x(ex0), .o_err_y(ey0), .o_err_z(ez0),
      .o_total_errors(tot0), .o_first_err_idx(fidx0), .o_vec_count(vc0)
   );

   wire4_check_sequencer #(.CNT_W(4), .SEED(SEED)) u_dut1 (
      .i_clk(clk), .i_reset(rst), .i_start(start1), .i_num_vectors(nv1),
      .o_abc(abc1), .i_wxyz(wxyz1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
      .o_err_w(ew1), .o_err_x(ex1), .o_err_y(ey1), .o_err_z(ez1),
      .o_total_errors(tot1), .o_first_err_idx(fidx1), .o_vec_count(vc1)
   );

   function automatic res_t get_res(input int w);
      res_t r;
      if (w == 0) begin
         r = {busy0, done0, pass0, abc0, ew0, ex0, ey0, ez0, tot0, fidx0, vc0};
      end else begin
         r = {busy1, done1, pass1, abc1, {12'd0, ew1}, {12'd0, ex1}, {12'd0, ey1},
              {12'd0, ez1}, {12'd0, tot1}, {12'd0, fidx1}, {12'd0, vc1}};
      end
      return r;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // Reference: walk the LFSR sequence, count mismatches against {a,b,b,c}
   function automatic res_t model(input int n, input int md, input int wbits,
                                  input logic [2:0] prev);
      res_t r;
      int c[4];
      int tot, fidx, maxv;
      logic [15:0] s;
      logic [2:0] v;
      logic [3:0] m;
      maxv = (1 << wbits) - 1;
      for (int b = 0; b < 4; b++) c[b] = 0;
      tot = 0; fidx = maxv; s = SEED; r.abc = prev;
      for (int i = 0; i < n; i++) begin
         v = s[2:0];
         m = {v[2], v[1], v[1], v[0]} ^ resp(v, md);
         for (int b = 0; b < 4; b++) if (m[b]) c[b]++;
         if (m != 4'd0) begin
            if (tot == 0) fidx = i;
            tot++;
         end
         r.abc = v;
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      end
      r.busy = 1'b0; r.done = 1'b0; r.pass = (tot == 0);
      r.ew = 16'(sat(c[3], maxv)); r.ex = 16'(sat(c[2], maxv));
      r.ey = 16'(sat(c[1], maxv)); r.ez = 16'(sat(c[0], maxv));
      r.tot = 16'(sat(tot, maxv)); r.fidx = 16'(fidx); r.vc = 16'(n);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input res_t a, input res_t e);
      chk({tag, ".busy"}, 32'(a.busy), 32'(e.busy));
      chk({tag, ".done"}, 32'(a.done), 32'(e.done));
      chk({tag, ".pass"}, 32'(a.pass), 32'(e.pass));
      chk({tag, ".abc"},  32'(a.abc),  32'(e.abc));
      chk({tag, ".err_w"}, 32'(a.ew), 32'(e.ew));
      chk({tag, ".err_x"}, 32'(a.ex), 32'(e.ex));
      chk({tag, ".err_y"}, 32'(a.ey), 32'(e.ey));
      chk({tag, ".err_z"}, 32'(a.ez), 32'(e.ez));
      chk({tag, ".total"}, 32'(a.tot), 32'(e.tot));
      chk({tag, ".first_idx"}, 32'(a.fidx), 32'(e.fidx));
      chk({tag, ".vec_count"}, 32'(a.vc), 32'(e.vc));
   endtask

   task automatic run(input int w, input int n, input int md, input string tag);
      res_t e;
      int cyc;
      bit got;
      e = model(n, md, (w == 0) ? 16 : 4, last_abc[w]);
      @(negedge clk);
      if (w == 0) begin mode0 = md; start0 = 1'b1; nv0 = 16'(n); end
      else        begin mode1 = md; start1 = 1'b1; nv1 = 4'(n); end
      @(posedge clk);
      #1;
      start0 = 1'b0; start1 = 1'b0;
      chk({tag, ".busy_c1"}, 32'(get_res(w).busy), 32'd1);
      cyc = 1; got = 1'b0;
      while (!got && cyc < 2 * n + 40) begin
         @(negedge clk);
         if (get_res(w).done) got = 1'b1;
         else begin @(posedge clk); cyc++; end
      end
      chk({tag, ".done_seen"}, 32'(got), 32'd1);
      chk({tag, ".done_cycle"}, 32'(cyc), 32'(2 * n + 1));
      @(posedge clk);
      #1;
      chk_res(tag, get_res(w), e);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ".held_vc"}, 32'(get_res(w).vc), 32'(e.vc));
      chk({tag, ".held_tot"}, 32'(get_res(w).tot), 32'(e.tot));
      last_abc[w] = e.abc;
   endtask

   res_t rst_exp0;
   int   ndone;

   initial begin
      last_abc[0] = '0; last_abc[1] = '0;
      rst_exp0 = model(0, 0, 16, 3'd0);
      rst_exp0.pass = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_res("reset", get_res(0), rst_exp0);

      run(0, 0, 0, "t4_zero");
      run(0, 8, 0, "t1_ideal");
      run(0, 100, 1, "t2_zstuck");
      run(0, 16, 2, "t3_swap");
      run(1, 15, 3, "t5_inv_a");
      run(1, 15, 3, "t5_inv_b");

      // Abort during CHECK of vector 5 of a 20-vector run
      @(negedge clk);
      mode0 = 1; start0 = 1'b1; nv0 = 16'd20;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      ndone = 0;
      for (int c = 1; c < 12; c++) begin
         @(negedge clk);
         if (done0) ndone++;
         @(posedge clk);
      end
      #2;
      rst = 1'b1;
      #1;
      chk("t6.no_done_before", 32'(ndone), 32'd0);
      chk_res("t6_in_reset", get_res(0), rst_exp0);
      @(negedge clk);
      rst = 1'b0;
      last_abc[0] = '0; last_abc[1] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_res("t6_after_reset", get_res(0), rst_exp0);
      run(0, 20, 1, "t6_fresh");

      for (int k = 0; k < 6; k++) run(0, int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), "rand0");
      for (int k = 0; k < 2; k++) run(1, int'($urandom_range(1, 15)), int'($urandom_range(0, 3)), "rand1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
